// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared FSM state encoding and the Q3 reference truth table
package truth_table_sweeper_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
    localparam logic [15:0] Q3_TABLE = 16'h1BBB;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control, result and lab-circuit signals of the sweeper
interface truth_table_sweeper_if #(parameter int N_IN = 4);
    logic                 start;
    logic                 dut_w;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   table_out;
    logic [N_IN:0]        mismatch_cnt;
    logic [N_IN-1:0]      first_fail;
    modport master (
        input  start, dut_w,
        output vec_out, busy, done, pass, table_out, mismatch_cnt, first_fail
    );
    modport slave (
        output start, dut_w,
        input  vec_out, busy, done, pass, table_out, mismatch_cnt, first_fail
    );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// truth_table_sweeper_settle_timer: loadable down-counter that flags when it has reached zero
module truth_table_sweeper_settle_timer #(parameter int W = 1) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    // load wins; otherwise count down and rest at zero
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector through a lab circuit and checks its truth table
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                 N_IN          = 4,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [2**N_IN-1:0] EXPECTED      = Q3_TABLE
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_sweeper_if.master bus
);
    localparam int              TW     = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [TW-1:0]   RELOAD = TW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [N_IN-1:0] LAST   = {N_IN{1'b1}};
    // with no settle time each vector is sampled the cycle it is applied
    localparam state_e          WAIT_ST = SETTLE_CYCLES > 0 ? SETTLE : SAMPLE;

    state_e               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d, ff_q, ff_d;
    logic [2**N_IN-1:0]   table_q, table_d;
    logic [N_IN:0]        mis_q, mis_d;
    logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                 load, zero, fail;

    truth_table_sweeper_settle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (RELOAD),
        .zero     (zero)
    );

    // next state and datapath; X/Z on the lab output never matches the expected bit
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ff_d    = ff_q;
        table_d = table_q;
        mis_d   = mis_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        load    = 1'b0;
        fail    = (bus.dut_w !== EXPECTED[vec_q]);
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = WAIT_ST;
                vec_d   = '0;
                ff_d    = '0;
                table_d = '0;
                mis_d   = '0;
                pass_d  = 1'b0;
                busy_d  = 1'b1;
                load    = 1'b1;
            end
            SETTLE: state_d = zero ? SAMPLE : SETTLE;
            SAMPLE: begin
                table_d[vec_q] = (bus.dut_w === 1'b1);
                if (fail) begin
                    mis_d = mis_q + 1'b1;
                    ff_d  = (mis_q == '0) ? vec_q : ff_q;
                end
                if (vec_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (mis_d == '0);
                end else begin
                    state_d = WAIT_ST;
                    vec_d   = vec_q + 1'b1;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ff_q    <= '0;
            table_q <= '0;
            mis_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ff_q    <= ff_d;
            table_q <= table_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end

    assign bus.vec_out      = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.table_out    = table_q;
    assign bus.mismatch_cnt = mis_q;
    assign bus.first_fail   = ff_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps against a cycle-level model of the sweep timing and results
`timescale 1ns/1ns
module tb_truth_table_sweeper;
    localparam int          S   = 4;
    localparam int          L   = 16 * (S + 1) + 1;
    localparam logic [15:0] EXP = 16'h1BBB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          mode = 0;
    int          errs = 0;
    int          chks = 0;
    bit          active = 1'b0;
    int          c = 0;
    logic        obs [16];
    logic [15:0] exp_tab = EXP;
    logic [3:0]  m_vec = '0;
    logic [15:0] m_tab = '0;
    logic [4:0]  m_mis = '0;
    logic [3:0]  m_ff = '0;
    logic        m_pass = 1'b0;

    truth_table_sweeper_if #(.N_IN(4)) bus ();
    truth_table_sweeper_if #(.N_IN(4)) bus0 ();

    truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    always #5 clk = ~clk;

    // lab circuit stand-ins: 0 ideal Q3, 1 stuck 0, 2 floating X, 3 stuck 1, 4 Q3 with vector 9 wrong
    function automatic logic lab_w(input int m, input logic [3:0] v);
        logic [15:0] t;
        t = EXP;
        case (m)
            1:       return 1'b0;
            2:       return 1'bx;
            3:       return 1'b1;
            4:       return t[v] ^ (v == 4'd9);
            default: return t[v];
        endcase
    endfunction

    always_comb bus.dut_w = lab_w(mode, bus.vec_out);
    always_comb bus0.dut_w = lab_w(0, bus0.vec_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vec"},   bus.vec_out, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_pass"},  bus.pass, 0);
        check({tag, "_table"}, bus.table_out, 0);
        check({tag, "_mis"},   bus.mismatch_cnt, 0);
        check({tag, "_ff"},    bus.first_fail, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    // called in cycle 1 of a sweep; returns at the done cycle with lat = its cycle number
    task automatic wait_done(input bit repulse, input int rst_at, output int lat);
        lat = 1;
        while (!bus.done && lat < 200) begin
            if (lat == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_vals("midrst");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                lat = -1;
                return;
            end
            bus.start = repulse && (lat == 5 || lat == 40);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("done_seen", bus.done, 1);
    endtask

    initial begin
        int lat;
        bus.start  = 1'b0;
        bus0.start = 1'b0;
        fork
            // sweep position: cycle c counts from 1 after the edge that accepts start
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    active = 1'b0;
                    c = 0;
                end else if (active) begin
                    if (c == L) active = 1'b0;
                    else c++;
                end else if (bus.start) begin
                    active = 1'b1;
                    c = 1;
                end
            end
            // per-cycle comparison against the model
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    m_vec = '0; m_tab = '0; m_mis = '0; m_ff = '0; m_pass = 1'b0;
                end else begin
                    if (active && c < L) begin
                        m_vec = 4'((c - 1) / (S + 1));
                        if (c % (S + 1) == 0) obs[m_vec] = bus.dut_w;
                    end
                    if (active && c == L) begin
                        m_tab = '0; m_mis = '0; m_ff = '0;
                        for (int i = 15; i >= 0; i--) begin
                            m_tab[i] = (obs[i] === 1'b1);
                            if (obs[i] !== exp_tab[i]) begin
                                m_mis++;
                                m_ff = 4'(i);
                            end
                        end
                        m_pass = (m_mis == 0);
                    end
                    check("m_busy", bus.busy, active && c < L);
                    check("m_done", bus.done, active && c == L);
                    check("m_vec", bus.vec_out, m_vec);
                    if (active && c < L) begin
                        check("m_pass_clr", bus.pass, 0);
                    end else begin
                        check("m_table", bus.table_out, m_tab);
                        check("m_mis", bus.mismatch_cnt, m_mis);
                        check("m_ff", bus.first_fail, m_ff);
                        check("m_pass", bus.pass, m_pass);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        mode = 0; pulse_start(); wait_done(0, 0, lat);
        check("q3_lat", lat, 81);
        check("q3_pass", bus.pass, 1);
        check("q3_table", bus.table_out, 16'h1BBB);
        check("q3_mis", bus.mismatch_cnt, 0);

        mode = 1; pulse_start(); wait_done(0, 0, lat);
        check("zero_pass", bus.pass, 0);
        check("zero_table", bus.table_out, 0);
        check("zero_mis", bus.mismatch_cnt, 10);
        check("zero_ff", bus.first_fail, 0);

        mode = 2; pulse_start(); wait_done(0, 0, lat);
        check("x_pass", bus.pass, 0);

        mode = 3; pulse_start(); wait_done(0, 0, lat);
        check("one_table", bus.table_out, 16'hFFFF);
        check("one_mis", bus.mismatch_cnt, 6);
        check("one_ff", bus.first_fail, 2);

        mode = 4; pulse_start(); wait_done(0, 0, lat);
        check("flip_table", bus.table_out, 16'h19BB);
        check("flip_mis", bus.mismatch_cnt, 1);
        check("flip_ff", bus.first_fail, 9);
        check("flip_pass", bus.pass, 0);

        mode = 0; pulse_start(); wait_done(1, 0, lat);
        check("repulse_lat", lat, 81);
        check("repulse_pass", bus.pass, 1);

        // start held through the done cycle: ignored there, accepted in the following idle cycle
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk) bus.start = 1'b0;
        wait_done(0, 0, lat);
        check("b2b_lat", lat, 81);
        check("b2b_pass", bus.pass, 1);

        mode = 1; pulse_start(); wait_done(0, 30, lat);
        check("rst_abort", lat, -1);
        mode = 0; pulse_start(); wait_done(0, 0, lat);
        check("after_rst_lat", lat, 81);
        check("after_rst_pass", bus.pass, 1);
        check("after_rst_table", bus.table_out, 16'h1BBB);

        @(negedge clk) bus0.start = 1'b1;
        @(negedge clk) bus0.start = 1'b0;
        lat = 1;
        while (!bus0.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("s0_lat", lat, 17);
        check("s0_pass", bus0.pass, 1);
        check("s0_table", bus0.table_out, 16'h1BBB);
        check("s0_mis", bus0.mismatch_cnt, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
